// File: rtl/udp_pkg.sv
// Shared types for the UDP receive path: header layout, parser states, sizes.
package udp_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned UDP_FIELD_W   = 16;

  // Field order matches wire order, so a 64-bit big-endian capture casts directly.
  typedef struct packed {
    logic [UDP_FIELD_W-1:0] src_port;
    logic [UDP_FIELD_W-1:0] dst_port;
    logic [UDP_FIELD_W-1:0] length;
    logic [UDP_FIELD_W-1:0] checksum;
  } udp_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN
  } udp_parse_state_e;

endpackage

// File: rtl/byte_out_reg.sv
// Single-entry valid/ready output register carrying one data word plus a last flag.
module byte_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              ready_c,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  // The caller only pushes while ready_c is high, so a held word is never overwritten.
  assign ready_c = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (push) begin
      m_valid <= 1'b1;
      m_data  <= push_data;
      m_last  <= push_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_header_parser.sv
// Strips the 8-byte UDP header from a byte stream, forwards the payload and
// drives the downstream payload counter, flagging length and truncation errors.
module udp_header_parser
  import udp_pkg::*;
#(
  parameter logic [15:0] MAX_UDP_LEN = 16'd1480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_length,
  output logic [15:0] checksum,
  output logic        hdr_valid,
  output logic        counter_rst,
  output logic        counter_enable,
  output logic        err_len,
  output logic        err_trunc
);

  localparam int unsigned HDR_BYTES = UDP_HDR_BYTES;
  localparam int unsigned IDX_W     = $clog2(HDR_BYTES);
  localparam int unsigned SHIFT_W   = (HDR_BYTES - 1) * 8;

  udp_parse_state_e   state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        rem_q, rem_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  udp_hdr_t           hdr_q, hdr_d, hdr_full_c;
  logic               hdr_valid_d, counter_rst_d, err_len_d, err_trunc_d;
  logic               accept_c, out_ready_c, push_c, push_last_c, len_ok_c;

  assign s_ready        = (state_q == PAYLOAD) ? out_ready_c : 1'b1;
  assign accept_c       = s_valid && s_ready;
  assign counter_enable = accept_c && (state_q == PAYLOAD);
  assign push_c         = counter_enable;
  assign push_last_c    = (rem_q == 16'd1) || s_last;

  // Header bytes 0-6 sit in the shift register; byte 7 completes it combinationally.
  assign hdr_full_c = udp_hdr_t'({shift_q, s_data});
  assign len_ok_c   = (hdr_full_c.length >= 16'(HDR_BYTES)) &&
                      (hdr_full_c.length <= MAX_UDP_LEN);

  assign src_port   = hdr_q.src_port;
  assign dst_port   = hdr_q.dst_port;
  assign udp_length = hdr_q.length;
  assign checksum   = hdr_q.checksum;

  byte_out_reg #(
    .DATA_W (8)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (s_data),
    .push_last (push_last_c),
    .ready_c   (out_ready_c),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      shift_q     <= '0;
      hdr_q       <= '0;
      hdr_valid   <= 1'b0;
      counter_rst <= 1'b0;
      err_len     <= 1'b0;
      err_trunc   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      hdr_q       <= hdr_d;
      hdr_valid   <= hdr_valid_d;
      counter_rst <= counter_rst_d;
      err_len     <= err_len_d;
      err_trunc   <= err_trunc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    shift_d       = shift_q;
    hdr_d         = hdr_q;
    hdr_valid_d   = 1'b0;
    counter_rst_d = 1'b0;
    err_len_d     = 1'b0;
    err_trunc_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          shift_d = {shift_q[SHIFT_W-9:0], s_data};
          if (s_last) begin
            err_trunc_d = 1'b1;
          end else begin
            state_d = HEADER;
            idx_d   = IDX_W'(1);
          end
        end
      end

      HEADER: begin
        if (accept_c) begin
          shift_d = {shift_q[SHIFT_W-9:0], s_data};
          if (idx_q == IDX_W'(HDR_BYTES - 1)) begin
            hdr_d         = hdr_full_c;
            hdr_valid_d   = 1'b1;
            counter_rst_d = 1'b1;
            idx_d         = '0;
            if (!len_ok_c) begin
              err_len_d = 1'b1;
              state_d   = s_last ? IDLE : DRAIN;
            end else if (hdr_full_c.length == 16'(HDR_BYTES)) begin
              err_len_d = !s_last;
              state_d   = s_last ? IDLE : DRAIN;
            end else if (s_last) begin
              // Header promises payload but the frame ended on its last byte.
              err_trunc_d = 1'b1;
              state_d     = IDLE;
            end else begin
              rem_d   = hdr_full_c.length - 16'(HDR_BYTES);
              state_d = PAYLOAD;
            end
          end else if (s_last) begin
            err_trunc_d = 1'b1;
            idx_d       = '0;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      PAYLOAD: begin
        if (accept_c) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            err_len_d = !s_last;
            state_d   = s_last ? IDLE : DRAIN;
          end else if (s_last) begin
            err_trunc_d = 1'b1;
            rem_d       = '0;
            state_d     = IDLE;
          end
        end
      end

      DRAIN: begin
        if (accept_c && s_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/udp_header_parser.md
Name: udp_header_parser

Overview:
- Upstream stage of the UDP payload path. Accepts a byte stream that starts at the first byte of the UDP header.
- Extracts the 8-byte big-endian header (src port, dst port, length, checksum), then forwards payload bytes downstream through a registered valid/ready output.
- Drives `udp_length`, `counter_rst` and `counter_enable` for the downstream payload byte counter.
- Tracks the remaining payload itself so it can generate `m_last` and flag length/framing errors.

Parameters:
- MAX_UDP_LEN, 16'd1480: largest legal udp_length; anything above is a length error.
- HDR_BYTES, 8: UDP header size in bytes; fixed, not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  8  input byte
- s_valid  in  1  input byte valid
- s_last  in  1  last byte of input frame
- s_ready  out  1  input accept
- m_data  out  8  payload byte
- m_valid  out  1  payload byte valid
- m_last  out  1  last payload byte
- m_ready  in  1  downstream accept
- src_port  out  16  latched header field
- dst_port  out  16  latched header field
- udp_length  out  16  latched header length (header + payload)
- checksum  out  16  latched header field
- hdr_valid  out  1  one-cycle pulse: header fields updated
- counter_rst  out  1  one-cycle pulse to payload counter at header completion
- counter_enable  out  1  high for each accepted payload byte
- err_len  out  1  one-cycle pulse: length illegal or frame longer than udp_length
- err_trunc  out  1  one-cycle pulse: s_last before udp_length satisfied

Behaviour:
- Reset values:
  - all outputs 0 except `s_ready` = 1;
  - state IDLE, byte index 0, remaining count 0.
- Handshake:
  - a byte transfers when `s_valid && s_ready`;
  - `s_ready` = 1 in IDLE, HEADER and DRAIN;
  - `s_ready` = (!m_valid || m_ready) in PAYLOAD.
- Output register:
  - `m_valid` holds until `m_ready`; `m_data`/`m_last` stable while `m_valid && !m_ready`;
  - latency is 1 cycle from input accept to `m_valid`.
- States:
  - IDLE: the first accepted byte is header byte 0 → HEADER (index 1).
  - HEADER: bytes stored by index. Index 0-1 src_port, 2-3 dst_port, 4-5 udp_length, 6-7 checksum, MSB first. On accepting byte 7, the fields update on the same edge.
    - Next cycle: `hdr_valid` = 1, `counter_rst` = 1.
    - udp_length < 8 or > MAX_UDP_LEN: `err_len` pulse; → DRAIN, or → IDLE if byte 7 had `s_last`.
    - udp_length == 8 with `s_last` on byte 7: → IDLE, no payload.
    - udp_length == 8 without `s_last`: `err_len`; → DRAIN.
    - Otherwise: remaining = udp_length − 8; → PAYLOAD.
    - `s_last` on header bytes 0-6: `err_trunc` pulse; → IDLE; fields not updated; no `hdr_valid`.
  - PAYLOAD: each accepted byte is forwarded, remaining is decremented, and `counter_enable` = 1 that cycle (combinational with the handshake).
    - `m_last` = 1 when remaining == 1 or `s_last`.
    - remaining == 1 with `s_last`: → IDLE.
    - remaining == 1 without `s_last`: `err_len`; → DRAIN.
    - `s_last` with remaining > 1: `err_trunc`, `m_last` still set; → IDLE.
  - DRAIN: accept and discard bytes with no `m_valid` and no `counter_enable`; `s_last` → IDLE.
- Field outputs hold their value until the next complete header, so `udp_length` is stable for the whole payload.
- Back-to-back frames: after return to IDLE, the next byte may be accepted the following cycle.
- The 16-bit subtraction udp_length − 8 happens only after the range check, so there is no wrap.
- Error pulses are registered and last one cycle. `err_len` and `err_trunc` never assert together.
- Reset mid-frame: everything returns to reset values immediately (asynchronous), including dropping `m_valid`.

Decomposition:
- Package `udp_pkg`:
  - `udp_hdr_t` packed struct (src_port, dst_port, length, checksum);
  - `UDP_HDR_BYTES = 8`;
  - state enum `udp_parse_state_e` {IDLE, HEADER, PAYLOAD, DRAIN}.
- One natural sub-module: `byte_out_reg`, a single-entry valid/ready output register carrying data+last. All other logic stays in the top module.

Test Plan:
- Frame of 12 bytes, header 04 D2 00 50 00 0C AB CD + payload 11 22 33 44, `s_last` on 44, `m_ready` = 1:
  - src_port = 0x04D2, dst_port = 0x0050, udp_length = 12, checksum = 0xABCD;
  - one `hdr_valid` and one `counter_rst` pulse;
  - 4 output bytes with `m_last` only on 0x44;
  - `counter_enable` high exactly 4 cycles.
- Same frame with `m_ready` toggling 1/0 every cycle:
  - identical output sequence, no byte loss or duplication;
  - `s_ready` low whenever the output register is full and `m_ready` = 0.
- Header length = 0x0006:
  - `err_len` pulse after byte 7;
  - remaining bytes dropped; no `m_valid`; IDLE after `s_last`.
- Header length = 16, but `s_last` on payload byte 3:
  - 3 bytes out, `m_last` on byte 3, one `err_trunc` pulse, return to IDLE.
- Header length = 9, frame has 11 bytes:
  - 1 payload byte out with `m_last`;
  - `err_len` pulse; 2 extra bytes dropped.
- Assert `rst_n` low during payload byte 2 of a 20-byte frame:
  - all outputs to reset values;
  - next frame parses correctly with new fields.
